// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage. Takes one instruction per valid/ready
// handshake from execute. Loads and stores go to the data-memory port
// through a request/response FSM with one access outstanding; all other
// instructions pass straight through. Every result is registered toward
// writeback, with load data lane-aligned and sign/zero-extended.
//
// Ports
//   clock, reset              : clock, synchronous active-high reset
//   flush_valid               : kill the in-flight instruction
//   instr_valid_from_upper / instr_ready_to_upper : upstream handshake
//   is_load, is_store, is_unsigned, ls_size, ls_address, store_data,
//   payload                   : operation from execute
//   mem_req_*                 : data-memory request channel
//   mem_resp_valid/_rdata     : data-memory response (always accepted)
//   instr_valid_to_lower / instr_ready_from_lower : downstream handshake
//   lower_payload, lower_opload_read_data_wb, lower_misaligned : result
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int unsigned PAYLOAD_W = 256
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_valid,
    input  logic                 instr_valid_from_upper,
    output logic                 instr_ready_to_upper,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_unsigned,
    input  logic [3:0]           ls_size,
    input  logic [63:0]          ls_address,
    input  logic [63:0]          store_data,
    input  logic [PAYLOAD_W-1:0] payload,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_write,
    output logic [63:0]          mem_req_addr,
    output logic [63:0]          mem_req_wdata,
    output logic [7:0]           mem_req_wmask,
    input  logic                 mem_resp_valid,
    input  logic [63:0]          mem_resp_rdata,
    output logic                 instr_valid_to_lower,
    input  logic                 instr_ready_from_lower,
    output logic [PAYLOAD_W-1:0] lower_payload,
    output logic [63:0]          lower_opload_read_data_wb,
    output logic                 lower_misaligned
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned SIZE_W = 4;
    localparam int unsigned OFF_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state, state_next;

    // Latched memory operation (drives the request channel while in REQ)
    logic                 op_write,    op_write_next;
    logic                 op_unsigned, op_unsigned_next;
    logic [SIZE_W-1:0]    op_size,     op_size_next;
    logic [OFF_W-1:0]     op_off,      op_off_next;
    logic [XLEN-1:0]      op_addr,     op_addr_next;
    logic [XLEN-1:0]      op_wdata,    op_wdata_next;
    logic [MASK_W-1:0]    op_wmask,    op_wmask_next;
    logic [PAYLOAD_W-1:0] op_payload,  op_payload_next;

    // Output register next values
    logic                 out_valid_next;
    logic [PAYLOAD_W-1:0] out_payload_next;
    logic [XLEN-1:0]      out_data_next;
    logic                 out_misaligned_next;

    // Decode helpers
    logic              is_mem;
    logic              size_onehot;
    logic              addr_unaligned;
    logic              misaligned;
    logic              accept;
    logic [MASK_W-1:0] size_mask;
    logic [XLEN-1:0]   shifted_rdata;
    logic [XLEN-1:0]   load_data;

    assign is_mem = is_load | is_store;

    // New work is taken only in IDLE and only when the output slot frees up
    assign instr_ready_to_upper = (state == IDLE) &
                                  (~instr_valid_to_lower | instr_ready_from_lower);
    assign accept = instr_valid_from_upper & instr_ready_to_upper & ~flush_valid;

    assign mem_req_valid = (state == REQ);
    assign mem_req_write = op_write;
    assign mem_req_addr  = op_addr;
    assign mem_req_wdata = op_wdata;
    assign mem_req_wmask = op_wmask;

    // Access-size decode and alignment check on the incoming op
    always_comb begin
        size_onehot    = 1'b1;
        addr_unaligned = 1'b0;
        size_mask      = '0;
        case (ls_size)
            4'b0001: size_mask = 8'h01;
            4'b0010: begin
                size_mask      = 8'h03;
                addr_unaligned = ls_address[0];
            end
            4'b0100: begin
                size_mask      = 8'h0F;
                addr_unaligned = |ls_address[1:0];
            end
            4'b1000: begin
                size_mask      = 8'hFF;
                addr_unaligned = |ls_address[2:0];
            end
            default: size_onehot = 1'b0;
        endcase
        misaligned = is_mem & (addr_unaligned | ~size_onehot);
    end

    // Response lane extraction and extension for the latched load
    always_comb begin
        shifted_rdata = mem_resp_rdata >> {op_off, 3'b000};
        case (op_size)
            4'b0001: load_data = op_unsigned ? XLEN'(shifted_rdata[7:0])
                                             : {{56{shifted_rdata[7]}}, shifted_rdata[7:0]};
            4'b0010: load_data = op_unsigned ? XLEN'(shifted_rdata[15:0])
                                             : {{48{shifted_rdata[15]}}, shifted_rdata[15:0]};
            4'b0100: load_data = op_unsigned ? XLEN'(shifted_rdata[31:0])
                                             : {{32{shifted_rdata[31]}}, shifted_rdata[31:0]};
            default: load_data = shifted_rdata;
        endcase
    end

    // Next-state, latched-op and output-register logic
    always_comb begin
        state_next          = state;
        op_write_next       = op_write;
        op_unsigned_next    = op_unsigned;
        op_size_next        = op_size;
        op_off_next         = op_off;
        op_addr_next        = op_addr;
        op_wdata_next       = op_wdata;
        op_wmask_next       = op_wmask;
        op_payload_next     = op_payload;
        out_valid_next      = instr_valid_to_lower;
        out_payload_next    = lower_payload;
        out_data_next       = lower_opload_read_data_wb;
        out_misaligned_next = lower_misaligned;

        // Consumed downstream: valid drops, data fields hold
        if (instr_valid_to_lower & instr_ready_from_lower) begin
            out_valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mem & ~misaligned) begin
                        op_write_next    = is_store;
                        op_unsigned_next = is_unsigned;
                        op_size_next     = ls_size;
                        op_off_next      = ls_address[2:0];
                        op_addr_next     = {ls_address[XLEN-1:3], 3'b000};
                        op_wdata_next    = store_data << {ls_address[2:0], 3'b000};
                        op_wmask_next    = size_mask << ls_address[2:0];
                        op_payload_next  = payload;
                        state_next       = REQ;
                    end else begin
                        out_valid_next      = 1'b1;
                        out_payload_next    = payload;
                        out_data_next       = '0;
                        out_misaligned_next = misaligned;
                    end
                end
            end
            REQ: begin
                // An accepted request still owes a response, so flush must drain it
                if (flush_valid) begin
                    state_next = mem_req_ready ? DRAIN : IDLE;
                end else if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_next = IDLE;
                    if (~flush_valid) begin
                        out_valid_next      = 1'b1;
                        out_payload_next    = op_payload;
                        out_data_next       = op_write ? '0 : load_data;
                        out_misaligned_next = 1'b0;
                    end
                end else if (flush_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The single owed response retires the drain even under flush
                if (mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (flush_valid) begin
            out_valid_next = 1'b0;
        end
    end

    // State and register update
    always_ff @(posedge clock) begin
        if (reset) begin
            state                     <= IDLE;
            op_write                  <= 1'b0;
            op_unsigned               <= 1'b0;
            op_size                   <= '0;
            op_off                    <= '0;
            op_addr                   <= '0;
            op_wdata                  <= '0;
            op_wmask                  <= '0;
            op_payload                <= '0;
            instr_valid_to_lower      <= 1'b0;
            lower_payload             <= '0;
            lower_opload_read_data_wb <= '0;
            lower_misaligned          <= 1'b0;
        end else begin
            state                     <= state_next;
            op_write                  <= op_write_next;
            op_unsigned               <= op_unsigned_next;
            op_size                   <= op_size_next;
            op_off                    <= op_off_next;
            op_addr                   <= op_addr_next;
            op_wdata                  <= op_wdata_next;
            op_wmask                  <= op_wmask_next;
            op_payload                <= op_payload_next;
            instr_valid_to_lower      <= out_valid_next;
            lower_payload             <= out_payload_next;
            lower_opload_read_data_wb <= out_data_next;
            lower_misaligned          <= out_misaligned_next;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
// Directed scenarios followed by a randomized stream. Expected results are
// queued when an instruction is handed over; a monitor thread pops and
// compares whenever the stage delivers a result downstream. A memory model
// thread checks each request against a second expectation queue.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int PW     = 256;
    localparam int N_RAND = 300;

    logic          clock;
    logic          reset;
    logic          flush_valid;
    logic          instr_valid_from_upper;
    logic          instr_ready_to_upper;
    logic          is_load;
    logic          is_store;
    logic          is_unsigned;
    logic [3:0]    ls_size;
    logic [63:0]   ls_address;
    logic [63:0]   store_data;
    logic [PW-1:0] payload;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_write;
    logic [63:0]   mem_req_addr;
    logic [63:0]   mem_req_wdata;
    logic [7:0]    mem_req_wmask;
    logic          mem_resp_valid;
    logic [63:0]   mem_resp_rdata;
    logic          instr_valid_to_lower;
    logic          instr_ready_from_lower;
    logic [PW-1:0] lower_payload;
    logic [63:0]   lower_opload_read_data_wb;
    logic          lower_misaligned;

    mem_access_stage #(.PAYLOAD_W(PW)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .flush_valid               (flush_valid),
        .instr_valid_from_upper    (instr_valid_from_upper),
        .instr_ready_to_upper      (instr_ready_to_upper),
        .is_load                   (is_load),
        .is_store                  (is_store),
        .is_unsigned               (is_unsigned),
        .ls_size                   (ls_size),
        .ls_address                (ls_address),
        .store_data                (store_data),
        .payload                   (payload),
        .mem_req_valid             (mem_req_valid),
        .mem_req_ready             (mem_req_ready),
        .mem_req_write             (mem_req_write),
        .mem_req_addr              (mem_req_addr),
        .mem_req_wdata             (mem_req_wdata),
        .mem_req_wmask             (mem_req_wmask),
        .mem_resp_valid            (mem_resp_valid),
        .mem_resp_rdata            (mem_resp_rdata),
        .instr_valid_to_lower      (instr_valid_to_lower),
        .instr_ready_from_lower    (instr_ready_from_lower),
        .lower_payload             (lower_payload),
        .lower_opload_read_data_wb (lower_opload_read_data_wb),
        .lower_misaligned          (lower_misaligned)
    );

    typedef struct packed {
        logic [PW-1:0] pl;
        logic [63:0]   data;
        logic          mis;
    } exp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [63:0] mem_img [16];
    int          n_chk;
    int          n_bad;
    bit          run;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_pl(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pl();
        logic [PW-1:0] v;
        for (int i = 0; i < PW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic int size_bytes(input logic [3:0] sz);
        case (sz)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 0;
        endcase
    endfunction

    // Pick nb bytes starting at byte off of the word, then extend
    function automatic logic [63:0] ref_load(input logic [63:0] word, input int off,
                                             input int nb, input bit uns);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        if (!uns && nb < 8 && v[8*nb-1]) begin
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_op();
        instr_valid_from_upper = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_unsigned = 1'b0;
    endtask

    // Directed aligned memory op with a zero-wait memory
    task automatic mem_op(input string tag, input bit st, input bit uns, input logic [3:0] sz,
                          input logic [63:0] addr, input logic [63:0] sd, input logic [63:0] rd,
                          input logic [63:0] exp_addr, input logic [63:0] exp_data,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wmask);
        logic [PW-1:0] pl;
        pl = rand_pl();
        is_load     = !st;
        is_store    = st;
        is_unsigned = uns;
        ls_size     = sz;
        ls_address  = addr;
        store_data  = sd;
        payload     = pl;
        instr_valid_from_upper = 1'b1;
        exp_q.push_back('{pl, exp_data, 1'b0});
        @(negedge clock);
        check({tag, "_ready"}, 64'(instr_ready_to_upper), 64'd1);
        tick();
        clear_op();
        mem_req_ready = 1'b1;
        @(negedge clock);
        check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
        check({tag, "_req_addr"}, mem_req_addr, exp_addr);
        check({tag, "_req_write"}, 64'(mem_req_write), 64'(st));
        if (st) begin
            check({tag, "_req_wdata"}, mem_req_wdata, exp_wdata);
            check({tag, "_req_wmask"}, 64'(mem_req_wmask), 64'(exp_wmask));
        end
        tick();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rd;
        @(negedge clock);
        check({tag, "_req_gone"}, 64'(mem_req_valid), 64'd0);
        check({tag, "_early_valid"}, 64'(instr_valid_to_lower), 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        @(negedge clock);
        check({tag, "_out_valid"}, 64'(instr_valid_to_lower), 64'd1);
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        run   = 1'b0;
        reset = 1'b1;
        flush_valid = 1'b0;
        clear_op();
        ls_size        = 4'b0001;
        ls_address     = '0;
        store_data     = '0;
        payload        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        instr_ready_from_lower = 1'b1;
        for (int i = 0; i < 16; i++) mem_img[i] = {$urandom, $urandom};

        fork
            // Monitor: compare each delivered result with the oldest expectation
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clock);
                    if (!reset && instr_valid_to_lower && instr_ready_from_lower) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_bad++;
                            $display("FAIL out_unexpected: got payload %h want none", lower_payload);
                        end else begin
                            e = exp_q.pop_front();
                            check_pl("out_payload", lower_payload, e.pl);
                            check("out_data", lower_opload_read_data_wb, e.data);
                            check("out_misaligned", 64'(lower_misaligned), 64'(e.mis));
                        end
                    end
                end
            end

            begin : sequence_thr
                logic [PW-1:0] pl;

                // Reset state
                repeat (2) @(posedge clock);
                @(negedge clock);
                check("rst_valid", 64'(instr_valid_to_lower), 64'd0);
                check("rst_req_valid", 64'(mem_req_valid), 64'd0);
                check("rst_data", lower_opload_read_data_wb, 64'd0);
                check("rst_mis", 64'(lower_misaligned), 64'd0);
                check("rst_req_addr", mem_req_addr, 64'd0);
                check("rst_wmask", 64'(mem_req_wmask), 64'd0);
                check("rst_ready", 64'(instr_ready_to_upper), 64'd1);
                tick();
                reset = 1'b0;
                tick();

                // Four back-to-back non-memory ops
                for (int i = 0; i < 4; i++) begin
                    pl = rand_pl();
                    payload     = pl;
                    ls_size     = 4'b0100;
                    ls_address  = {$urandom, $urandom};
                    instr_valid_from_upper = 1'b1;
                    exp_q.push_back('{pl, 64'd0, 1'b0});
                    @(negedge clock);
                    check("nm_ready", 64'(instr_ready_to_upper), 64'd1);
                    if (i > 0) check("nm_valid", 64'(instr_valid_to_lower), 64'd1);
                    tick();
                end
                clear_op();
                @(negedge clock);
                check("nm_valid_last", 64'(instr_valid_to_lower), 64'd1);
                tick();
                @(negedge clock);
                check("nm_valid_off", 64'(instr_valid_to_lower), 64'd0);
                tick();

                // Byte loads, signed and unsigned
                mem_op("lb", 1'b0, 1'b0, 4'b0001, 64'h1003, 64'd0, 64'h0000_0000_8000_0000,
                       64'h1000, 64'hFFFF_FFFF_FFFF_FF80, 64'd0, 8'd0);
                mem_op("lbu", 1'b0, 1'b1, 4'b0001, 64'h1003, 64'd0, 64'h0000_0000_8000_0000,
                       64'h1000, 64'h0000_0000_0000_0080, 64'd0, 8'd0);
                // Half store in the top lanes
                mem_op("sh", 1'b1, 1'b0, 4'b0010, 64'h2006, 64'h1234, 64'hDEAD_BEEF_0000_0000,
                       64'h2000, 64'd0, 64'h1234_0000_0000_0000, 8'hC0);

                // Misaligned word load: no request, flagged result next cycle
                pl = rand_pl();
                payload    = pl;
                is_load    = 1'b1;
                ls_size    = 4'b0100;
                ls_address = 64'h3002;
                instr_valid_from_upper = 1'b1;
                exp_q.push_back('{pl, 64'd0, 1'b1});
                @(negedge clock);
                check("mis_ready", 64'(instr_ready_to_upper), 64'd1);
                tick();
                clear_op();
                @(negedge clock);
                check("mis_no_req", 64'(mem_req_valid), 64'd0);
                check("mis_valid", 64'(instr_valid_to_lower), 64'd1);
                tick();

                // Request back-pressure, then downstream back-pressure
                pl = rand_pl();
                payload    = pl;
                is_load    = 1'b1;
                ls_size    = 4'b1000;
                ls_address = 64'h4008;
                instr_valid_from_upper = 1'b1;
                exp_q.push_back('{pl, 64'hFEDC_BA98_7654_3210, 1'b0});
                @(negedge clock);
                check("stall_acc_ready", 64'(instr_ready_to_upper), 64'd1);
                tick();
                clear_op();
                ls_address = 64'hFFFF_FFFF_FFFF_FFFF;
                for (int i = 0; i < 4; i++) begin
                    if (i == 3) mem_req_ready = 1'b1;
                    @(negedge clock);
                    check("stall_req_valid", 64'(mem_req_valid), 64'd1);
                    check("stall_req_addr", mem_req_addr, 64'h4008);
                    check("stall_req_write", 64'(mem_req_write), 64'd0);
                    check("stall_up_ready", 64'(instr_ready_to_upper), 64'd0);
                    tick();
                end
                mem_req_ready  = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 64'hFEDC_BA98_7654_3210;
                instr_ready_from_lower = 1'b0;
                tick();
                mem_resp_valid = 1'b0;
                mem_resp_rdata = '0;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clock);
                    check("hold_valid", 64'(instr_valid_to_lower), 64'd1);
                    check("hold_data", lower_opload_read_data_wb, 64'hFEDC_BA98_7654_3210);
                    check_pl("hold_payload", lower_payload, pl);
                    check("hold_up_ready", 64'(instr_ready_to_upper), 64'd0);
                    tick();
                end
                instr_ready_from_lower = 1'b1;
                @(negedge clock);
                check("drain_up_ready", 64'(instr_ready_to_upper), 64'd1);
                tick();
                @(negedge clock);
                check("consumed_valid", 64'(instr_valid_to_lower), 64'd0);
                check("consumed_data_hold", lower_opload_read_data_wb, 64'hFEDC_BA98_7654_3210);
                tick();

                // Flush in REQ without ready: request withdrawn, back to IDLE
                is_load    = 1'b1;
                ls_size    = 4'b0100;
                ls_address = 64'h5000;
                payload    = rand_pl();
                instr_valid_from_upper = 1'b1;
                @(negedge clock);
                check("fr_ready", 64'(instr_ready_to_upper), 64'd1);
                tick();
                clear_op();
                flush_valid = 1'b1;
                @(negedge clock);
                check("fr_req_valid", 64'(mem_req_valid), 64'd1);
                tick();
                flush_valid = 1'b0;
                @(negedge clock);
                check("fr_withdrawn", 64'(mem_req_valid), 64'd0);
                check("fr_idle_ready", 64'(instr_ready_to_upper), 64'd1);
                tick();

                // Flush in WAIT: drain the late response, then accept again
                is_load    = 1'b1;
                ls_size    = 4'b1000;
                ls_address = 64'h6000;
                payload    = rand_pl();
                instr_valid_from_upper = 1'b1;
                @(negedge clock);
                tick();
                clear_op();
                mem_req_ready = 1'b1;
                tick();
                mem_req_ready = 1'b0;
                flush_valid   = 1'b1;
                tick();
                flush_valid = 1'b0;
                pl = rand_pl();
                payload = pl;
                instr_valid_from_upper = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    @(negedge clock);
                    check("fw_up_ready", 64'(instr_ready_to_upper), 64'd0);
                    check("fw_no_valid", 64'(instr_valid_to_lower), 64'd0);
                    check("fw_no_req", 64'(mem_req_valid), 64'd0);
                    tick();
                end
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 64'h1111_2222_3333_4444;
                @(negedge clock);
                check("fw_resp_up_ready", 64'(instr_ready_to_upper), 64'd0);
                tick();
                mem_resp_valid = 1'b0;
                exp_q.push_back('{pl, 64'd0, 1'b0});
                @(negedge clock);
                check("fw_discard", 64'(instr_valid_to_lower), 64'd0);
                check("fw_next_ready", 64'(instr_ready_to_upper), 64'd1);
                tick();
                clear_op();
                @(negedge clock);
                check("fw_next_valid", 64'(instr_valid_to_lower), 64'd1);
                tick();

                // Reset while waiting for a response
                is_load    = 1'b1;
                ls_size    = 4'b0001;
                ls_address = 64'h7000;
                instr_valid_from_upper = 1'b1;
                @(negedge clock);
                tick();
                clear_op();
                mem_req_ready = 1'b1;
                tick();
                mem_req_ready = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                @(negedge clock);
                check("rw_ready", 64'(instr_ready_to_upper), 64'd1);
                check("rw_req_valid", 64'(mem_req_valid), 64'd0);
                check("rw_valid", 64'(instr_valid_to_lower), 64'd0);
                tick();

                // Randomized stream
                run = 1'b1;
                fork
                    begin : stim
                        int cls, nb, off;
                        bit acc, mis, uns;
                        logic [3:0]  sz;
                        logic [63:0] addr, sd, data;
                        req_t r;
                        for (int n = 0; n < N_RAND; n++) begin
                            cls = $urandom_range(0, 2);
                            if ($urandom_range(0, 7) == 0) sz = 4'($urandom_range(0, 15));
                            else sz = 4'(1 << $urandom_range(0, 3));
                            nb = size_bytes(sz);
                            if (nb != 0 && $urandom_range(0, 1) == 1) off = nb * $urandom_range(0, (8 / nb) - 1);
                            else off = $urandom_range(0, 7);
                            addr = {$urandom, $urandom};
                            addr[2:0] = 3'(off);
                            sd  = {$urandom, $urandom};
                            uns = 1'($urandom_range(0, 1));
                            pl  = rand_pl();
                            is_load     = (cls == 1);
                            is_store    = (cls == 2);
                            is_unsigned = uns;
                            ls_size     = sz;
                            ls_address  = addr;
                            store_data  = sd;
                            payload     = pl;
                            instr_valid_from_upper = 1'b1;
                            acc = 1'b0;
                            for (int w = 0; w < 200 && !acc; w++) begin
                                @(negedge clock);
                                if (instr_ready_to_upper) acc = 1'b1;
                                tick();
                            end
                            if (!acc) begin
                                n_chk++;
                                n_bad++;
                                $display("FAIL rand_accept_timeout: got no ready want ready op %0d", n);
                            end else begin
                                mis = (cls != 0) && (nb == 0 || (off % nb) != 0);
                                if (cls == 0 || mis) begin
                                    exp_q.push_back('{pl, 64'd0, mis});
                                end else begin
                                    data = (cls == 1) ? ref_load(mem_img[addr[6:3]], off, nb, uns) : 64'd0;
                                    exp_q.push_back('{pl, data, 1'b0});
                                    r.addr  = {addr[63:3], 3'b000};
                                    r.write = (cls == 2);
                                    r.wdata = sd << (8 * off);
                                    r.wmask = '0;
                                    for (int b = 0; b < nb; b++) r.wmask[off + b] = 1'b1;
                                    req_q.push_back(r);
                                end
                            end
                            clear_op();
                            repeat ($urandom_range(0, 2)) tick();
                        end
                        for (int w = 0; w < 1000 && exp_q.size() != 0; w++) @(negedge clock);
                        check("rand_out_left", 64'(exp_q.size()), 64'd0);
                        check("rand_req_left", 64'(req_q.size()), 64'd0);
                        run = 1'b0;
                    end
                    begin : lower_side
                        while (run) begin
                            tick();
                            instr_ready_from_lower = ($urandom_range(0, 3) != 0);
                        end
                        instr_ready_from_lower = 1'b1;
                    end
                    begin : mem_side
                        int dly;
                        bit pend;
                        logic [63:0] rd;
                        req_t r;
                        pend = 1'b0;
                        dly  = 0;
                        rd   = '0;
                        while (run) begin
                            tick();
                            mem_resp_valid = 1'b0;
                            if (pend) begin
                                if (dly == 0) begin
                                    mem_resp_valid = 1'b1;
                                    mem_resp_rdata = rd;
                                    pend = 1'b0;
                                end else begin
                                    dly--;
                                end
                            end
                            mem_req_ready = ($urandom_range(0, 2) != 0);
                            @(negedge clock);
                            if (mem_req_valid && mem_req_ready) begin
                                if (req_q.size() == 0) begin
                                    n_chk++;
                                    n_bad++;
                                    $display("FAIL req_unexpected: got addr %h want none", mem_req_addr);
                                end else begin
                                    r = req_q.pop_front();
                                    check("req_addr", mem_req_addr, r.addr);
                                    check("req_write", 64'(mem_req_write), 64'(r.write));
                                    if (r.write) begin
                                        check("req_wdata", mem_req_wdata, r.wdata);
                                        check("req_wmask", 64'(mem_req_wmask), 64'(r.wmask));
                                    end
                                end
                                pend = 1'b1;
                                dly  = $urandom_range(0, 3);
                                rd   = mem_req_write ? {$urandom, $urandom} : mem_img[mem_req_addr[6:3]];
                            end
                        end
                        mem_req_ready  = 1'b0;
                        mem_resp_valid = 1'b0;
                    end
                join
            end
        join_any

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage between the execute-to-memory pipeline register and the memory-to-writeback pipeline register. It takes one instruction at a time over a valid/ready handshake. Loads and stores go to the data-memory port through a request/response FSM; every other instruction passes straight through. Each result is registered toward writeback with the load result aligned and extended into `lower_opload_read_data_wb`.

## Interface
- `PAYLOAD_W`, default 256: opaque sideband bundle (pc, instr, preg/lreg fields, ALU/BJU/muldiv results); carried unmodified.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `flush_valid` in 1: kill in-flight instruction.
- `instr_valid_from_upper` in 1; `instr_ready_to_upper` out 1: upstream handshake.
- `is_load`, `is_store`, `is_unsigned` in 1 each: operation class and extension mode.
- `ls_size` in 4: one-hot access size; 0001 byte, 0010 half, 0100 word, 1000 dword.
- `ls_address` in 64: effective byte address.
- `store_data` in 64: store operand, LSB-aligned.
- `payload` in PAYLOAD_W: sideband bundle.
- `mem_req_valid` out 1; `mem_req_ready` in 1: memory request handshake.
- `mem_req_write` out 1: 1 = store.
- `mem_req_addr` out 64: `ls_address` with bits [2:0] cleared.
- `mem_req_wdata` out 64; `mem_req_wmask` out 8: lane-shifted store data and byte mask.
- `mem_resp_valid` in 1; `mem_resp_rdata` in 64: one response per accepted request, loads and stores alike; always accepted.
- `instr_valid_to_lower` out 1; `instr_ready_from_lower` in 1: downstream handshake.
- `lower_payload` out PAYLOAD_W.
- `lower_opload_read_data_wb` out 64: extended load data; 0 for non-loads.
- `lower_misaligned` out 1: misaligned or illegal-size memory op; no access was made.

## Operation
- States: IDLE, REQ, WAIT, DRAIN. Reset → IDLE. Every output register resets to 0.
- `instr_ready_to_upper` = (state==IDLE) & (~instr_valid_to_lower | instr_ready_from_lower).
- Accept in IDLE (non-memory op, or misaligned memory op):
  - Load the output registers; `instr_valid_to_lower`=1 next cycle.
  - State stays IDLE.
- Misaligned means any of:
  - half with addr[0]≠0;
  - word with addr[1:0]≠0;
  - dword with addr[2:0]≠0;
  - `ls_size` not one-hot while `is_load|is_store`.
- Accept in IDLE (aligned load/store): latch the operation into an internal register; state → REQ.
- REQ:
  - `mem_req_valid`=1; `mem_req_addr`, `mem_req_write`, `mem_req_wdata`, `mem_req_wmask` come from the latched op and are stable until accepted.
  - On `mem_req_ready` → WAIT.
- Store lane placement, with off = addr[2:0]:
  - wdata = store_data << (8·off).
  - wmask = {1,3,15,255}[size] << off.
- WAIT: on `mem_resp_valid` → IDLE and load the output registers with `instr_valid_to_lower`=1.
  - Load data: (rdata >> 8·off) truncated to the access size, then sign-extended, or zero-extended when `is_unsigned`.
  - Stores output data 0.
- Output-register hazard: a memory op is accepted only when the output is empty or draining that cycle, and no new valid is generated in REQ or WAIT. A WAIT completion therefore always finds the output register empty.
- Output holds its value while `instr_valid_to_lower & ~instr_ready_from_lower`. If it is consumed without a new load the same cycle, valid → 0 and the data fields hold.
- Flush (priority below reset, above everything else):
  - `instr_valid_to_lower` → 0.
  - IDLE → IDLE.
  - REQ without `mem_req_ready` this cycle → IDLE; the request is withdrawn.
  - REQ with `mem_req_ready` this cycle → DRAIN.
  - WAIT without `mem_resp_valid` → DRAIN.
  - WAIT with `mem_resp_valid` → IDLE; the response is discarded.
  - DRAIN → DRAIN.
  - A same-cycle upstream accept is ignored.
- DRAIN: `instr_ready_to_upper`=0; on `mem_resp_valid` the response is discarded → IDLE.

## Timing
- Non-memory op: accepted cycle N → `instr_valid_to_lower` at N+1.
- Memory op: accepted N → `mem_req_valid` at N+1. With ready at N+1, state is WAIT from N+2. A response at cycle M gives output valid at M+1.
- Minimum memory-op latency is accept-to-output 3 cycles: zero-wait ready and response in the first WAIT cycle.
- Throughput is 1/cycle for non-memory ops. Memory ops are blocking: one outstanding.
- `reset` is sampled at the clock edge; it wins over `flush_valid` and all handshakes. Reset mid-WAIT returns to IDLE with no drain; the memory side is reset together with this block.

## Test plan
- Non-memory stream of 4 back-to-back ops, lower always ready → outputs at N+1..N+4, payload unchanged, `lower_opload_read_data_wb`=0.
- Load byte, signed, addr 0x1003, rdata 0x00000000_80000000 → `mem_req_addr`=0x1000, output data 0xFFFFFFFF_FFFFFF80. Repeat with `is_unsigned` → 0x80.
- Store half, addr 0x2006, store_data 0x1234 → `mem_req_wdata`=0x1234_0000_0000_0000, `mem_req_wmask`=0xC0, `mem_req_write`=1, output valid after response.
- Load word, addr 0x3002 → no `mem_req_valid`, output at N+1 with `lower_misaligned`=1, data 0.
- `mem_req_ready` held 0 for 3 cycles, then 1; downstream ready low 2 cycles at output → request fields stable throughout, output held stable, `instr_ready_to_upper`=0 until drained.
- Flush in WAIT → state DRAIN, late response discarded, no `instr_valid_to_lower`, next op accepted the cycle after the response.
